// File: rtl/id_inst_buffer.sv
// rtl/id_inst_buffer.sv - decode-side instruction capture (BIOS/IMEM select, stall hold, squash)
// Optional perf counters enabled by defining FETCH_PERF_EN.
module id_inst_buffer #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall,
    input  logic             ex_br_mispred,
    input  logic             if_bios_en,
    input  logic [31:0]      bios_dout,
    input  logic [31:0]      imem_dout,
    output logic [31:0]      id_inst,
    output logic             id_inst_valid,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_squash_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        src_sel_q;
    logic [31:0] hold_q;
    logic [31:0] hold_d;
    logic        hold_v_q;
    logic        hold_v_d;
    logic [31:0] live_word;
    logic [31:0] pre_inst;
    logic        pre_valid;

    // Source select tracks the address cycle, so it must freeze with the fetch PC.
    assign live_word = src_sel_q ? bios_dout : imem_dout;

    always_comb begin
        pre_inst  = NOP_INST;
        pre_valid = 1'b0;
        case (state_q)
            ST_RUN: begin
                pre_inst  = live_word;
                pre_valid = 1'b1;
            end
            ST_HOLD: begin
                pre_inst  = hold_q;
                pre_valid = hold_v_q;
            end
            default: begin
                pre_inst  = NOP_INST;
                pre_valid = 1'b0;
            end
        endcase
    end

    assign id_inst       = ex_br_mispred ? NOP_INST : pre_inst;
    assign id_inst_valid = ex_br_mispred ? 1'b0 : pre_valid;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        case (state_q)
            ST_BOOT: begin
                if (id_stall) begin
                    state_d  = ST_HOLD;
                    hold_d   = NOP_INST;
                    hold_v_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (id_stall) begin
                    state_d  = ST_HOLD;
                    hold_d   = live_word;
                    hold_v_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!id_stall) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        // A squashed word caught by a stall must stay a bubble for the whole stall.
        if (ex_br_mispred && id_stall) begin
            state_d  = ST_HOLD;
            hold_d   = NOP_INST;
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_BOOT;
            src_sel_q <= 1'b0;
            hold_q    <= NOP_INST;
            hold_v_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            if (!id_stall) begin
                src_sel_q <= if_bios_en;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] squash_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (state_q == ST_HOLD) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ex_br_mispred && pre_valid) begin
                squash_cnt_q <= squash_cnt_q + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_squash_count = squash_cnt_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_squash_count = '0;
`endif

endmodule

// File: tb/tb_id_inst_buffer.sv
// tb/tb_id_inst_buffer.sv - table-driven scoreboard bench for id_inst_buffer
module tb_id_inst_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        id_stall;
    logic        ex_br_mispred;
    logic        if_bios_en;
    logic [31:0] bios_dout;
    logic [31:0] imem_dout;
    logic [31:0] id_inst;
    logic        id_inst_valid;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_squash_count;

    id_inst_buffer #(.NOP_INST(NOP), .CNT_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_stall          (id_stall),
        .ex_br_mispred     (ex_br_mispred),
        .if_bios_en        (if_bios_en),
        .bios_dout         (bios_dout),
        .imem_dout         (imem_dout),
        .id_inst           (id_inst),
        .id_inst_valid     (id_inst_valid),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_squash_count (perf_squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        mispred;
        logic        bios_en;
        logic [31:0] bios;
        logic [31:0] imem;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] stall_c;
        logic [31:0] squash_c;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] stall_c;
        logic [31:0] squash_c;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic s, input logic m, input logic b,
                       input logic [31:0] bd, input logic [31:0] id,
                       input logic [31:0] ei, input logic ev,
                       input logic [31:0] es, input logic [31:0] eq);
        vec_t v;
        v.rst = r; v.stall = s; v.mispred = m; v.bios_en = b;
        v.bios = bd; v.imem = id; v.inst = ei; v.valid = ev;
        v.stall_c  = PERF ? es : 32'd0;
        v.squash_c = PERF ? eq : 32'd0;
        vecs.push_back(v);
    endtask

    task automatic check32(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, req);
        end
    endtask

    // Drive one cycle: inputs just after the rising edge, outputs sampled at the falling edge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        rst = v.rst; id_stall = v.stall; ex_br_mispred = v.mispred;
        if_bios_en = v.bios_en; bios_dout = v.bios; imem_dout = v.imem;
        e.idx = idx; e.inst = v.inst; e.valid = v.valid;
        e.stall_c = v.stall_c; e.squash_c = v.squash_c;
        sb.push_back(e);
        n_vec++;
        @(negedge clk);
        got = sb.pop_front();
        check32("id_inst", got.idx, id_inst, got.inst);
        check32("id_inst_valid", got.idx, {31'd0, id_inst_valid}, {31'd0, got.valid});
        check32("perf_stall_cycles", got.idx, perf_stall_cycles, got.stall_c);
        check32("perf_squash_count", got.idx, perf_squash_count, got.squash_c);
    endtask

    initial begin
        vec_t hv;
        rst = 1'b0; id_stall = 1'b0; ex_br_mispred = 1'b0; if_bios_en = 1'b0;
        bios_dout = 32'h0; imem_dout = 32'h0;

        //   rst stl msp bio  bios          imem          inst          vld stall squash
        add(0, 0, 0, 0, 32'h0,        32'h00500093, NOP,          0, 0, 0); // 0 reset
        add(1, 0, 0, 0, 32'h0,        32'h00500093, NOP,          0, 0, 0); // 1 boot bubble
        add(1, 0, 0, 0, 32'h0,        32'h00500093, 32'h00500093, 1, 0, 0); // 2 first word
        add(1, 0, 0, 1, 32'hAAAA0537, 32'h11111111, 32'h11111111, 1, 0, 0); // 3 bios addr
        add(1, 0, 0, 0, 32'hAAAA0537, 32'h11111111, 32'hAAAA0537, 1, 0, 0); // 4 bios word
        add(1, 0, 0, 0, 32'h0,        32'h00A00113, 32'h00A00113, 1, 0, 0); // 5
        add(1, 1, 0, 0, 32'h0,        32'h00A00113, 32'h00A00113, 1, 0, 0); // 6 stall capture
        add(1, 1, 0, 0, 32'h0,        32'hDEADBEEF, 32'h00A00113, 1, 0, 0); // 7 hold
        add(1, 1, 0, 0, 32'h0,        32'hDEADBEEF, 32'h00A00113, 1, 1, 0); // 8 hold
        add(1, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'h00A00113, 1, 2, 0); // 9 release
        add(1, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1, 3, 0); // 10 live
        add(1, 1, 1, 0, 32'h0,        32'h00000293, NOP,          0, 3, 0); // 11 squash+stall
        add(1, 1, 1, 0, 32'h0,        32'h00000293, NOP,          0, 3, 1); // 12
        add(1, 0, 0, 0, 32'h0,        32'h00000293, NOP,          0, 4, 1); // 13 bubble held
        add(1, 0, 0, 0, 32'h0,        32'h00C00193, 32'h00C00193, 1, 5, 1); // 14
        add(1, 1, 0, 0, 32'h0,        32'h00C00193, 32'h00C00193, 1, 5, 1); // 15 capture
        add(1, 1, 0, 0, 32'h0,        32'hDEADBEEF, 32'h00C00193, 1, 5, 1); // 16 hold
        add(0, 1, 0, 0, 32'h0,        32'hDEADBEEF, NOP,          0, 0, 0); // 17 reset mid-hold
        add(1, 0, 0, 0, 32'h0,        32'h00700213, NOP,          0, 0, 0); // 18 boot bubble
        add(1, 0, 0, 0, 32'h0,        32'h00700213, 32'h00700213, 1, 0, 0); // 19
        add(0, 0, 0, 0, 32'h0,        32'h00700213, NOP,          0, 0, 0); // 20 reset
        add(1, 1, 0, 0, 32'h0,        32'h00700213, NOP,          0, 0, 0); // 21 stall in boot
        add(1, 0, 0, 0, 32'h0,        32'h00700213, NOP,          0, 0, 0); // 22 hold bubble
        add(1, 0, 0, 0, 32'h0,        32'h00800293, 32'h00800293, 1, 1, 0); // 23
        add(1, 0, 1, 0, 32'h0,        32'h00800293, NOP,          0, 1, 0); // 24 squash no stall
        add(1, 0, 0, 0, 32'h0,        32'h00900313, 32'h00900313, 1, 1, 1); // 25
        add(1, 1, 0, 1, 32'hBBBB0000, 32'h00100093, 32'h00100093, 1, 1, 1); // 26 bios_en ignored
        add(1, 0, 0, 0, 32'hBBBB0000, 32'hCCCCCCCC, 32'h00100093, 1, 1, 1); // 27 hold
        add(1, 0, 0, 0, 32'hBBBB0000, 32'h00200093, 32'h00200093, 1, 2, 1); // 28 imem kept

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset asserted while a squash and stall are both active.
        hv = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h00300093, NOP, 1'b0, 32'd2, 32'd1};
        hv.stall_c = PERF ? 32'd2 : 32'd0; hv.squash_c = PERF ? 32'd1 : 32'd0;
        apply(hv, 100);
        hv.rst = 1'b0; hv.stall_c = 32'd0; hv.squash_c = 32'd0;
        apply(hv, 101);
        hv = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h00300093, NOP, 1'b0, 32'd0, 32'd0};
        apply(hv, 102);
        hv.inst = 32'h00300093; hv.valid = 1'b1;
        apply(hv, 103);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
